counter16_rr_timer_arbiter: RTL
===============================

Name: counter16_rr_timer_arbiter

Overview:
Shares one 16-bit up-counter between NUM_REQ requesters, each asking for a timed interval of a given length.
- A round-robin arbiter picks one requester.
- The counter runs from 0 up to that requester's length minus 1.
- A one-cycle done pulse is returned to the winner, then the counter is released to the next requester.
- Sits between client blocks needing interval timing and the free-running counter datapath, all in the falling-edge clock0 domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 16, counter and length width in bits

Ports:
clock0  input  1  clock; all flops update on the falling edge of clock0
reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clock0
req  input  NUM_REQ  per-requester request level; held high until done, or dropped to abort
req_len  input  NUM_REQ*WIDTH  per-requester interval length, packed; slice i = bits [i*WIDTH +: WIDTH]
grant  output  NUM_REQ  one-hot owner of the counter; all-zero when idle
busy  output  1  high in COUNT or DONE
count  output  WIDTH  shared counter value
done  output  NUM_REQ  one-cycle completion pulse, one-hot, to the owner

Behaviour:
- Reset values: state=IDLE, grant=0, busy=0, count=0, done=0, len_q=0, owner=0, rr_ptr=NUM_REQ-1 (so requester 0 has first priority after reset).
- Reset is asynchronous: asserting it in any state, including mid-COUNT, forces the reset values at once. No done is issued for an interrupted interval.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If req != 0 at a falling edge, choose the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - On that edge: latch owner, latch len_q = req_len slice of owner, set grant[owner]=1, count=0.
  - If len_q (the sampled slice) == 0: go directly to DONE. Otherwise go to COUNT.
  - req_len is sampled only on this arbitration edge; later changes are ignored.
- COUNT:
  - count increments by 1 each edge.
  - On the edge where count == len_q-1, go to DONE and hold count at len_q-1.
  - So COUNT lasts exactly len_q cycles and count walks 0..len_q-1.
  - Max len_q = 2^WIDTH-1; count never wraps.
- DONE:
  - Lasts one cycle with done[owner]=1; grant and count are held.
  - Next edge: go to IDLE, grant=0, done=0, rr_ptr=owner, count held.
- Abort: if req[owner] is low at an edge in COUNT, go to IDLE with grant=0, done=0, rr_ptr=owner, count held. No done is issued.
- Non-owner req changes never affect the current interval.
- Latency: a request winning at edge k gets done high between edges k+len and k+len+1, or between k and k+1 for len=0.
- Back-to-back: at least one IDLE cycle separates consecutive grants.
- A requester that keeps req high after done competes again under round-robin. Another pending requester is served first.
- Invariants: grant and done are each zero or one-hot; done is only ever set for the bit set in grant.

Decomposition:
- Shared package: FSM state encoding (ST_IDLE, ST_COUNT, ST_DONE) and the default widths.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, valid flag.
  - Reusable by other arbiters in the codebase.
- Counter, FSM and length latch stay in the top module.

Test Plan:
- Reset mid-count: req[0]=1, len0=10; assert reset after count reaches 4 -> grant, count, done, busy go to 0 immediately. After release, req0 still high -> re-granted with count restarting at 0.
- Single request: req[2]=1, len2=5 -> grant=0100 on the next edge. count goes 0,1,2,3,4, then done=0100 for one cycle with count=4, then grant=0.
- Zero length: req[1]=1, len1=0 -> grant=0010 and done=0010 together for one cycle, then IDLE. Max length: len=16'hFFFF -> count reaches 16'hFFFE, no wrap, then done.
- Round-robin fairness: req=1111 held, all lengths 2 -> grant order 0,1,2,3,0. Each grant is separated by one IDLE cycle, and done matches the owner each time.
- Abort: req[3]=1, len3=8; drop req[3] at count=3 -> IDLE next edge, no done pulse, rr_ptr=3. Pending req[0] is granted next.
- Length sampling: change len0 from 6 to 2 during COUNT -> interval still completes at count=5.

Source files
------------

// File: rtl/counter16_rr_timer_arbiter_pkg.sv
// Shared definitions for the round-robin interval timer.
// FSM encoding and default widths.
package counter16_rr_timer_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/counter16_rr_timer_arbiter_if.sv
// Request/grant bundle between clients and the shared timer.
// master = client side, slave = timer side.
interface counter16_rr_timer_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [WIDTH-1:0]         count;
  logic [NUM_REQ-1:0]       done;

  modport master (
    output req, req_len,
    input  grant, busy, count, done
  );

  modport slave (
    input  req, req_len,
    output grant, busy, count, done
  );

endinterface

// File: rtl/counter16_rr_timer_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req
// bit searching upward from ptr+1, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win,
  output logic          valid
);

  // Farthest candidate first so the nearest one wins last.
  always_comb begin
    valid = 1'b0;
    win   = '0;
    for (int o = N; o >= 1; o--) begin
      if (req[IW'((int'(ptr) + o) % N)]) begin
        valid = 1'b1;
        win   = IW'((int'(ptr) + o) % N);
      end
    end
  end

endmodule

// File: rtl/counter16_rr_timer_arbiter.sv
// Shared 16-bit interval timer arbitrated round-robin
// among NUM_REQ requesters; falling-edge clock0 domain.
module counter16_rr_timer_arbiter
  import counter16_rr_timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input logic clock0,
  input logic reset,
  counter16_rr_timer_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  logic [1:0]         state;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      win;
  logic               win_vld;
  logic [WIDTH-1:0]   len_q;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   win_len;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] win_oh;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .win   (win),
    .valid (win_vld)
  );

  assign win_len = bus.req_len[int'(win)*WIDTH +: WIDTH];
  assign win_oh  = NUM_REQ'(1) << win;

  always_ff @(negedge clock0 or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= '0;
      rr_ptr  <= IW'(NUM_REQ - 1);
      len_q   <= '0;
      cnt     <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (win_vld) begin
            owner   <= win;
            len_q   <= win_len;
            grant_q <= win_oh;
            cnt     <= '0;
            // Zero-length interval completes on the grant edge.
            if (win_len == '0) begin
              state  <= ST_DONE;
              done_q <= win_oh;
            end else begin
              state <= ST_COUNT;
            end
          end
        end
        (state == ST_COUNT): begin
          if (!bus.req[owner]) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            rr_ptr  <= owner;
          end else if (cnt == len_q - 1'b1) begin
            state  <= ST_DONE;
            done_q <= grant_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        (state == ST_DONE): begin
          state   <= ST_IDLE;
          grant_q <= '0;
          done_q  <= '0;
          rr_ptr  <= owner;
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
          done_q  <= '0;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.count = cnt;
  assign bus.busy  = (state != ST_IDLE);

endmodule
